// File: rtl/issue_pkg.sv
// Shared types and constants for the dual-issue scheduler.
package issue_pkg;

  // PAIR: neither lane of the decode pair has issued yet.
  // SPLIT: lane 1 already issued, lane 2 still waiting in decode.
  typedef enum logic [0:0] {
    PAIR  = 1'b0,
    SPLIT = 1'b1
  } issue_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pair_hazard_check.sv
// Combinational hazard detection for the decoded instruction pair:
// intra-pair conflicts and load-use hazards against the execute stage.
module pair_hazard_check
  import issue_pkg::*;
(
  input  logic       ValidD1,
  input  logic       ValidD2,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdD1,
  input  logic [4:0] Rs4D,
  input  logic [4:0] Rs5D,
  input  logic [4:0] RdD2,
  input  logic       RegWriteD1,
  input  logic       RegWriteD2,
  input  logic       LoadD1,
  input  logic       StoreD1,
  input  logic       LoadD2,
  input  logic       StoreD2,
  input  logic       BranchD1,
  input  logic [1:0] JumpD1,
  input  logic [4:0] RdE1,
  input  logic [4:0] RdE2,
  input  logic       LoadE1,
  input  logic       LoadE2,
  output logic       pc,
  output logic       lu1,
  output logic       lu2
);

  // A source waits on a load in either execute lane; x0 never does.
  function automatic logic lu(input logic [4:0] x, input logic [4:0] rde1, input logic [4:0] rde2,
                              input logic lde1, input logic lde2);
    return (x != REG_ZERO) && ((lde1 && (x == rde1)) || (lde2 && (x == rde2)));
  endfunction

  logic raw, waw, mem2, ctl1;

  // Pair conflicts force a split; load-use forces a stall in the affected lane.
  always_comb begin
    raw  = RegWriteD1 && (RdD1 != REG_ZERO) && ((RdD1 == Rs4D) || (RdD1 == Rs5D));
    waw  = RegWriteD1 && RegWriteD2 && (RdD1 == RdD2) && (RdD1 != REG_ZERO);
    mem2 = (LoadD1 || StoreD1) && (LoadD2 || StoreD2);
    ctl1 = BranchD1 || (JumpD1 != 2'b00);
    pc   = ValidD1 && ValidD2 && (raw || waw || mem2 || ctl1);
    lu1  = ValidD1 && (lu(Rs1D, RdE1, RdE2, LoadE1, LoadE2) || lu(Rs2D, RdE1, RdE2, LoadE1, LoadE2));
    lu2  = ValidD2 && (lu(Rs4D, RdE1, RdE2, LoadE1, LoadE2) || lu(Rs5D, RdE1, RdE2, LoadE1, LoadE2));
  end

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue pairing and hazard scheduler: decides dual issue, split issue
// or load-use stall, drives F/D stall and per-lane E bubbles, counts stats.
module issue_scheduler
  import issue_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ValidD1,
  input  logic             ValidD2,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD1,
  input  logic [4:0]       Rs4D,
  input  logic [4:0]       Rs5D,
  input  logic [4:0]       RdD2,
  input  logic             RegWriteD1,
  input  logic             RegWriteD2,
  input  logic             LoadD1,
  input  logic             StoreD1,
  input  logic             LoadD2,
  input  logic             StoreD2,
  input  logic             BranchD1,
  input  logic [1:0]       JumpD1,
  input  logic [4:0]       RdE1,
  input  logic [4:0]       RdE2,
  input  logic             LoadE1,
  input  logic             LoadE2,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE1,
  output logic             FlushE2,
  output logic             IssueD1,
  output logic             IssueD2,
  output logic [CNT_W-1:0] CntDual,
  output logic [CNT_W-1:0] CntSingle,
  output logic [CNT_W-1:0] CntStall
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  issue_state_t state, state_nxt;
  logic         pc, lu1, lu2;

  pair_hazard_check u_hazard (
    .ValidD1    (ValidD1),
    .ValidD2    (ValidD2),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdD1       (RdD1),
    .Rs4D       (Rs4D),
    .Rs5D       (Rs5D),
    .RdD2       (RdD2),
    .RegWriteD1 (RegWriteD1),
    .RegWriteD2 (RegWriteD2),
    .LoadD1     (LoadD1),
    .StoreD1    (StoreD1),
    .LoadD2     (LoadD2),
    .StoreD2    (StoreD2),
    .BranchD1   (BranchD1),
    .JumpD1     (JumpD1),
    .RdE1       (RdE1),
    .RdE2       (RdE2),
    .LoadE1     (LoadE1),
    .LoadE2     (LoadE2),
    .pc         (pc),
    .lu1        (lu1),
    .lu2        (lu2)
  );

  // State register; reset abandons any pending lane 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= PAIR;
    else      state <= state_nxt;
  end

  // Next state and control decode; the defaults are the reset / idle outputs
  // (both lanes bubbled, nothing stalled), so reset only has to skip the decode.
  always_comb begin
    state_nxt = state;
    StallF    = 1'b0;
    StallD    = 1'b0;
    FlushD    = 1'b0;
    FlushE1   = 1'b1;
    FlushE2   = 1'b1;
    if (rst) begin
      if (PCSrcE) begin
        FlushD    = 1'b1;
        state_nxt = PAIR;
      end else if (state == PAIR) begin
        if (lu1) begin
          StallF = 1'b1;
          StallD = 1'b1;
        end else if (pc || lu2) begin
          FlushE1   = !ValidD1;
          StallF    = 1'b1;
          StallD    = 1'b1;
          state_nxt = SPLIT;
        end else begin
          FlushE1 = !ValidD1;
          FlushE2 = !ValidD2;
        end
      end else begin
        if (lu2) begin
          StallF = 1'b1;
          StallD = 1'b1;
        end else begin
          FlushE2   = !ValidD2;
          state_nxt = PAIR;
        end
      end
    end
    IssueD1 = ValidD1 && !FlushE1;
    IssueD2 = ValidD2 && !FlushE2;
  end

  // Issue statistics; redirect cycles are not counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      CntDual   <= '0;
      CntSingle <= '0;
      CntStall  <= '0;
    end else if (!PCSrcE) begin
      if (IssueD1 && IssueD2)      CntDual   <= CntDual + CNT_ONE;
      else if (IssueD1 ^ IssueD2)  CntSingle <= CntSingle + CNT_ONE;
      else if (StallD)             CntStall  <= CntStall + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed test-plan steps followed
// by randomized traffic, checked against a behavioural scheduling model.
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidD1, ValidD2;
  logic [4:0]  Rs1D, Rs2D, RdD1, Rs4D, Rs5D, RdD2;
  logic        RegWriteD1, RegWriteD2;
  logic        LoadD1, StoreD1, LoadD2, StoreD2;
  logic        BranchD1;
  logic [1:0]  JumpD1;
  logic [4:0]  RdE1, RdE2;
  logic        LoadE1, LoadE2, PCSrcE;
  logic        StallF, StallD, FlushD, FlushE1, FlushE2, IssueD1, IssueD2;
  logic [31:0] CntDual, CntSingle, CntStall;

  int total = 0;
  int bad   = 0;

  // Model state: lane 2 of the current pair still owed, plus expected counters.
  bit          pend = 0;
  logic [31:0] m_dual = 0, m_single = 0, m_stall = 0;

  issue_scheduler #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .ValidD1(ValidD1), .ValidD2(ValidD2),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD1(RdD1),
    .Rs4D(Rs4D), .Rs5D(Rs5D), .RdD2(RdD2),
    .RegWriteD1(RegWriteD1), .RegWriteD2(RegWriteD2),
    .LoadD1(LoadD1), .StoreD1(StoreD1), .LoadD2(LoadD2), .StoreD2(StoreD2),
    .BranchD1(BranchD1), .JumpD1(JumpD1),
    .RdE1(RdE1), .RdE2(RdE2), .LoadE1(LoadE1), .LoadE2(LoadE2),
    .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE1(FlushE1), .FlushE2(FlushE2),
    .IssueD1(IssueD1), .IssueD2(IssueD2),
    .CntDual(CntDual), .CntSingle(CntSingle), .CntStall(CntStall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Does register x have to wait for a load currently in execute?
  function automatic bit waits_on_load(input logic [4:0] x);
    if (x == 0) return 0;
    return (LoadE1 && x == RdE1) || (LoadE2 && x == RdE2);
  endfunction

  // Decision for the current cycle:
  // 0 reset, 1 redirect, 2 load-use stall, 3 first half of split, 4 pair issue, 5 second half.
  function automatic int decide();
    bit hz1, hz2, conflict;
    hz1 = ValidD1 && (waits_on_load(Rs1D) || waits_on_load(Rs2D));
    hz2 = ValidD2 && (waits_on_load(Rs4D) || waits_on_load(Rs5D));
    conflict = 0;
    if (ValidD1 && ValidD2) begin
      if (RegWriteD1 && RdD1 != 0 && (Rs4D == RdD1 || Rs5D == RdD1)) conflict = 1;
      if (RegWriteD1 && RegWriteD2 && RdD1 != 0 && RdD1 == RdD2)     conflict = 1;
      if ((LoadD1 || StoreD1) && (LoadD2 || StoreD2))                conflict = 1;
      if (BranchD1 || JumpD1 != 0)                                   conflict = 1;
    end
    if (!rst)   return 0;
    if (PCSrcE) return 1;
    if (!pend) begin
      if (hz1)             return 2;
      if (conflict || hz2) return 3;
      return 4;
    end
    if (hz2) return 2;
    return 5;
  endfunction

  // One clock: check combinational outputs and counters, then advance the model at the edge.
  task automatic run_cycle();
    int  k, n;
    bit  e_stall, e_fd, e_fe1, e_fe2, e_i1, e_i2;
    #1;
    if (!rst) begin
      pend = 0; m_dual = 0; m_single = 0; m_stall = 0;
    end
    k       = decide();
    e_stall = (k == 2) || (k == 3);
    e_fd    = (k == 1);
    e_fe1   = !((k == 3) || (k == 4)) || !ValidD1;
    e_fe2   = !((k == 4) || (k == 5)) || !ValidD2;
    e_i1    = ValidD1 && !e_fe1;
    e_i2    = ValidD2 && !e_fe2;
    check("StallF",    32'(StallF),  32'(e_stall));
    check("StallD",    32'(StallD),  32'(e_stall));
    check("FlushD",    32'(FlushD),  32'(e_fd));
    check("FlushE1",   32'(FlushE1), 32'(e_fe1));
    check("FlushE2",   32'(FlushE2), 32'(e_fe2));
    check("IssueD1",   32'(IssueD1), 32'(e_i1));
    check("IssueD2",   32'(IssueD2), 32'(e_i2));
    check("CntDual",   CntDual,   m_dual);
    check("CntSingle", CntSingle, m_single);
    check("CntStall",  CntStall,  m_stall);
    @(posedge clk);
    if (k >= 2) begin
      n = int'(e_i1) + int'(e_i2);
      if (n == 2)            m_dual++;
      else if (n == 1)       m_single++;
      else if (e_stall)      m_stall++;
    end
    case (k)
      1, 4, 5: pend = 0;
      3:       pend = 1;
      default: ;
    endcase
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ValidD1 = 0; ValidD2 = 0;
    Rs1D = 0; Rs2D = 0; RdD1 = 0; Rs4D = 0; Rs5D = 0; RdD2 = 0;
    RegWriteD1 = 0; RegWriteD2 = 0;
    LoadD1 = 0; StoreD1 = 0; LoadD2 = 0; StoreD2 = 0;
    BranchD1 = 0; JumpD1 = 0;
    RdE1 = 0; RdE2 = 0; LoadE1 = 0; LoadE2 = 0; PCSrcE = 0;
  endtask

  task automatic set_pair(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd1,
                          input logic [4:0] rs4, input logic [4:0] rs5, input logic [4:0] rd2);
    ValidD1 = 1; ValidD2 = 1; RegWriteD1 = 1; RegWriteD2 = 1;
    Rs1D = rs1; Rs2D = rs2; RdD1 = rd1; Rs4D = rs4; Rs5D = rs5; RdD2 = rd2;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    @(negedge clk);
    run_cycle();                                   // reset values
    rst = 1;

    set_pair(5'd1, 5'd2, 5'd5, 5'd3, 5'd4, 5'd6);  // independent pair
    run_cycle();
    check("dual_after_indep", CntDual, 32'd1);

    set_pair(5'd0, 5'd0, 5'd5, 5'd5, 5'd5, 5'd6);  // RAW pair
    run_cycle();
    run_cycle();
    check("single_after_raw", CntSingle, 32'd2);

    set_pair(5'd7, 5'd2, 5'd5, 5'd3, 5'd4, 5'd6);  // load-use on lane 1
    LoadE1 = 1; RdE1 = 5'd7;
    run_cycle();
    check("stall_after_lu", CntStall, 32'd1);
    LoadE1 = 0;
    run_cycle();
    check("dual_after_lu", CntDual, 32'd2);

    set_pair(5'd1, 5'd2, 5'd0, 5'd3, 5'd4, 5'd6);  // beq + independent, redirect mid-split
    RegWriteD1 = 0; BranchD1 = 1;
    run_cycle();
    PCSrcE = 1;
    run_cycle();
    PCSrcE = 0; BranchD1 = 0;

    set_pair(5'd1, 5'd0, 5'd5, 5'd2, 5'd0, 5'd6);  // both loads
    LoadD1 = 1; LoadD2 = 1;
    run_cycle();
    run_cycle();
    LoadD1 = 0; LoadD2 = 0;
    set_pair(5'd1, 5'd2, 5'd9, 5'd3, 5'd4, 5'd9);  // WAW on x9
    run_cycle();
    run_cycle();
    set_pair(5'd1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd6);  // rd1 = x0, lane 2 reads x0
    run_cycle();

    set_pair(5'd0, 5'd0, 5'd5, 5'd5, 5'd5, 5'd6);  // reset during split
    run_cycle();
    rst = 0;
    run_cycle();
    rst = 1;
    set_pair(5'd1, 5'd2, 5'd5, 5'd3, 5'd4, 5'd6);
    run_cycle();
    check("dual_after_reset", CntDual, 32'd1);

    for (int i = 0; i < 400; i++) begin
      rst        = ($urandom_range(0, 63) != 0);
      ValidD1    = ($urandom_range(0, 7) != 0);
      ValidD2    = ($urandom_range(0, 7) != 0);
      Rs1D       = 5'($urandom_range(0, 7));
      Rs2D       = 5'($urandom_range(0, 7));
      RdD1       = 5'($urandom_range(0, 7));
      Rs4D       = 5'($urandom_range(0, 7));
      Rs5D       = 5'($urandom_range(0, 7));
      RdD2       = 5'($urandom_range(0, 7));
      RegWriteD1 = 1'($urandom_range(0, 1));
      RegWriteD2 = 1'($urandom_range(0, 1));
      LoadD1     = ($urandom_range(0, 3) == 0);
      StoreD1    = ($urandom_range(0, 5) == 0);
      LoadD2     = ($urandom_range(0, 3) == 0);
      StoreD2    = ($urandom_range(0, 5) == 0);
      BranchD1   = ($urandom_range(0, 7) == 0);
      JumpD1     = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      RdE1       = 5'($urandom_range(0, 7));
      RdE2       = 5'($urandom_range(0, 7));
      LoadE1     = ($urandom_range(0, 2) == 0);
      LoadE2     = ($urandom_range(0, 2) == 0);
      PCSrcE     = ($urandom_range(0, 7) == 0);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

Dual-issue pairing and hazard scheduler sitting beside the two-lane decode stage. Each cycle it decides whether the decoded instruction pair issues together, splits into two single issues over consecutive cycles, or stalls for a load-use hazard. It drives the F/D stall and per-lane E flush (bubble) controls, handles redirect flushes, and keeps issue-statistics counters.

## Interface
- Parameters:
- `CNT_W`, 32, width of statistics counters
- Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `ValidD1`, `ValidD2`  in  1 each  decode register holds a real instruction in lane 1 / lane 2
- `Rs1D`, `Rs2D`, `RdD1`  in  5 each  lane 1 sources / destination
- `Rs4D`, `Rs5D`, `RdD2`  in  5 each  lane 2 sources / destination
- `RegWriteD1`, `RegWriteD2`  in  1 each  lane writes register file
- `LoadD1`, `StoreD1`, `LoadD2`, `StoreD2`  in  1 each  memory-op flags
- `BranchD1`  in  1; `JumpD1`  in  2  lane 1 control transfer (jump when `JumpD1 != 0`)
- `RdE1`, `RdE2`  in  5 each; `LoadE1`, `LoadE2`  in  1 each  execute-stage load destinations
- `PCSrcE`  in  1  execute redirect (taken branch/jump)
- `StallF`, `StallD`  out  1 each  hold PC / decode register
- `FlushD`  out  1  clear decode register
- `FlushE1`, `FlushE2`  out  1 each  inject bubble into lane 1 / lane 2 of execute
- `IssueD1`, `IssueD2`  out  1 each  lane issues into execute this cycle
- `CntDual`, `CntSingle`, `CntStall`  out  `CNT_W` each  statistics

## Operation
- State: `PAIR` (neither lane issued yet) or `SPLIT` (lane 1 already issued; lane 2 pending).
- `lu(x)`: `x != 0` and ((`LoadE1` and `x == RdE1`) or (`LoadE2` and `x == RdE2`)). `lu1` = lu(`Rs1D`)|lu(`Rs2D`) and `ValidD1`; `lu2` = lu(`Rs4D`)|lu(`Rs5D`) and `ValidD2`.
- Pair conflict `pc` (requires both valid): RAW (`RegWriteD1`, `RdD1 != 0`, `RdD1` equals `Rs4D` or `Rs5D`); WAW (both write, `RdD1 == RdD2 != 0`); both lanes memory ops (single data port); lane 1 branch/jump.
- Priority 1, `PCSrcE=1`: `FlushD=1`, `FlushE1=FlushE2=1`, no stall, next `PAIR`, no counter change.
- `PAIR`, `lu1`: full stall: `StallF=StallD=1`, `FlushE1=FlushE2=1`, stay `PAIR`.
- `PAIR`, not `lu1`, (`pc` or `lu2`): lane 1 issues, `FlushE2=1`, `StallF=StallD=1`, next `SPLIT`.
- `PAIR`, otherwise: valid lanes issue, no stall.
- `SPLIT`, `lu2`: `StallF=StallD=1`, `FlushE1=FlushE2=1`, stay `SPLIT`.
- `SPLIT`, otherwise: `FlushE1=1`, lane 2 issues, no stall, next `PAIR`.
- Invalid lane: its `FlushE` = 1 and `Issue` = 0; it never causes `pc` or lu stalls.
- `IssueDn` = `ValidDn` and not `FlushEn`; excludes redirect cycles.
- Counters, non-redirect cycles only: `CntDual`+1 when both issue; `CntSingle`+1 when exactly one issues; `CntStall`+1 when `StallD=1` and neither issues. All wrap modulo 2^`CNT_W`.

## Timing
- Control outputs are combinational from inputs and state, same cycle. State and counters update on the rising edge of `clk`.
- While `rst`=0: state `PAIR`, counters 0, `StallF=StallD=FlushD=0`, `FlushE1=FlushE2=1`, `IssueD1=IssueD2=0`. Reset asserted mid-`SPLIT` abandons the pending lane 2.
- A split pair takes 2 cycles; each load-use stall adds 1 cycle.
- Redirect during `SPLIT` discards the pending lane 2 and returns to `PAIR` the next cycle.
- Same-cycle writes to different registers through both write ports are legal; WAW pairs are always split.

## Structure
- Package `issue_pkg`: `issue_state_t` enum {`PAIR`, `SPLIT`}, `REG_ZERO` = 5'd0.
- Sub-module `pair_hazard_check` (combinational): computes `pc`, `lu1` and `lu2`. The top level holds the FSM, output decode and counters.

## Test plan
- Independent pair `add x5,x1,x2` / `sub x6,x3,x4`, no E loads -> `IssueD1=IssueD2=1`, no stall, `CntDual`=1.
- RAW pair `addi x5,x0,1` / `add x6,x5,x5` -> cycle 0: `IssueD1=1`, `FlushE2=1`, stalls=1. Cycle 1: `FlushE1=1`, `IssueD2=1`, no stall. `CntSingle`=2.
- `LoadE1=1`, `RdE1=7`, lane 1 reads x7 -> one cycle with all flushes and stalls, `CntStall`=1. Next cycle (`LoadE1=0`) the pair dual-issues.
- Lane 1 `beq`, lane 2 independent; `PCSrcE=1` in the `SPLIT` cycle -> `FlushD=1`, `FlushE1=FlushE2=1`, `IssueD2=0`, next state `PAIR`.
- Both lanes loads -> split. Both write x9 -> split. `RdD1=0` with lane 2 reading x0 -> dual-issue.
- Assert `rst`=0 during `SPLIT` -> outputs at reset values immediately; counters 0. After release, a fresh pair is treated from `PAIR`.
